// File: rtl/z16_pkg.sv
// Shared Z16 definitions: datapath width, arbiter port indices and the bus word type.
package z16_pkg;

    localparam int unsigned Z16_XLEN = 16;
    localparam int unsigned PORT_CPU = 0;
    localparam int unsigned PORT_DMA = 1;

    typedef logic [Z16_XLEN-1:0] z16_word_t;

endpackage

// File: rtl/z16_dmem_arbiter_if.sv
// Requester and data-memory signal bundle for the Z16 data-memory arbiter.
interface z16_dmem_arbiter_if;
    import z16_pkg::*;

    logic      i_req0;
    z16_word_t i_addr0;
    logic      i_wen0;
    z16_word_t i_wdata0;
    logic      o_gnt0;
    logic      o_rvalid0;
    z16_word_t o_rdata0;

    logic      i_req1;
    z16_word_t i_addr1;
    logic      i_wen1;
    z16_word_t i_wdata1;
    logic      o_gnt1;
    logic      o_rvalid1;
    z16_word_t o_rdata1;

    z16_word_t o_mem_addr;
    logic      o_mem_wen;
    z16_word_t o_mem_wdata;
    z16_word_t i_mem_rdata;

    // Requester / memory side.
    modport master (
        output i_req0, i_addr0, i_wen0, i_wdata0,
        output i_req1, i_addr1, i_wen1, i_wdata1,
        output i_mem_rdata,
        input  o_gnt0, o_rvalid0, o_rdata0,
        input  o_gnt1, o_rvalid1, o_rdata1,
        input  o_mem_addr, o_mem_wen, o_mem_wdata
    );

    // Arbiter side.
    modport slave (
        input  i_req0, i_addr0, i_wen0, i_wdata0,
        input  i_req1, i_addr1, i_wen1, i_wdata1,
        input  i_mem_rdata,
        output o_gnt0, o_rvalid0, o_rdata0,
        output o_gnt1, o_rvalid1, o_rdata1,
        output o_mem_addr, o_mem_wen, o_mem_wdata
    );

endinterface

// File: rtl/z16_rr_pick2.sv
// Two-way grant picker: a lone request wins; on contention either round-robin
// against the last grant or port 0 priority unless port 1 is being forced.
module z16_rr_pick2 #(
    parameter bit RR_MODE = 1'b1
) (
    input  logic [1:0] req_i,
    input  logic       last_gnt_i,
    input  logic       force1_i,
    output logic [1:0] gnt_o
);

    logic pick1;

    always_comb begin
        gnt_o = req_i;
        pick1 = 1'b0;
        if (req_i == 2'b11) begin
            if (RR_MODE) begin
                pick1 = ~last_gnt_i;
            end else begin
                pick1 = force1_i;
            end
            gnt_o = pick1 ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/z16_dmem_arbiter.sv
// Shares the single-port Z16 data memory between the CPU (port 0) and the DMA
// (port 1); load data is captured into a per-port register one cycle after grant.
module z16_dmem_arbiter
    import z16_pkg::*;
#(
    parameter bit          RR_MODE    = 1'b1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    z16_dmem_arbiter_if.slave bus
);

    localparam int unsigned      CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [1:0]       req_c;
    logic [1:0]       gnt_c;
    logic             force1_c;
    logic             load0_c;
    logic             load1_c;

    logic             last_gnt_q, last_gnt_d;
    logic [CNT_W-1:0] starve_q,   starve_d;
    logic             rvalid0_q,  rvalid0_d;
    logic             rvalid1_q,  rvalid1_d;
    z16_word_t        rdata0_q,   rdata0_d;
    z16_word_t        rdata1_q,   rdata1_d;

    assign req_c    = {bus.i_req1, bus.i_req0};
    assign force1_c = (starve_q == STARVE_LIM);

    z16_rr_pick2 #(
        .RR_MODE (RR_MODE)
    ) u_pick (
        .req_i      (req_c),
        .last_gnt_i (last_gnt_q),
        .force1_i   (force1_c),
        .gnt_o      (gnt_c)
    );

    assign bus.o_gnt0 = gnt_c[PORT_CPU];
    assign bus.o_gnt1 = gnt_c[PORT_DMA];

    // Memory-side mux; idle cycles present an all-zero, non-writing access.
    always_comb begin
        bus.o_mem_addr  = '0;
        bus.o_mem_wen   = 1'b0;
        bus.o_mem_wdata = '0;
        if (gnt_c[PORT_CPU]) begin
            bus.o_mem_addr  = bus.i_addr0;
            bus.o_mem_wen   = bus.i_wen0;
            bus.o_mem_wdata = bus.i_wdata0;
        end else if (gnt_c[PORT_DMA]) begin
            bus.o_mem_addr  = bus.i_addr1;
            bus.o_mem_wen   = bus.i_wen1;
            bus.o_mem_wdata = bus.i_wdata1;
        end
    end

    assign load0_c = gnt_c[PORT_CPU] & ~bus.i_wen0;
    assign load1_c = gnt_c[PORT_DMA] & ~bus.i_wen1;

    // Next-state for response registers, last grant and starvation counter.
    always_comb begin
        rvalid0_d  = load0_c;
        rvalid1_d  = load1_c;
        rdata0_d   = load0_c ? bus.i_mem_rdata : rdata0_q;
        rdata1_d   = load1_c ? bus.i_mem_rdata : rdata1_q;
        last_gnt_d = (|gnt_c) ? gnt_c[PORT_DMA] : last_gnt_q;
        starve_d   = starve_q;
        if (!bus.i_req1 || gnt_c[PORT_DMA]) begin
            starve_d = '0;
        end else if (gnt_c[PORT_CPU] && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            last_gnt_q <= 1'b1;
            starve_q   <= '0;
        end else begin
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            last_gnt_q <= last_gnt_d;
            starve_q   <= starve_d;
        end
    end

    assign bus.o_rvalid0 = rvalid0_q;
    assign bus.o_rvalid1 = rvalid1_q;
    assign bus.o_rdata0  = rdata0_q;
    assign bus.o_rdata1  = rdata1_q;

endmodule
